// File: rtl/control_sequencer_if.sv
// Bundle between the multicycle control sequencer and its environment.
// The "master" side supplies the opcode and memory handshake. The "slave"
// side is the sequencer, which returns the control state and status.
//
// Handshake: mem_ready is a completion strobe sampled on each rising clk
// edge while the sequencer sits in a memory state. These states are
// INSTRUCTION_FETCH, LOAD4 and STORE4. mem_ready=1 means the access finishes
// this cycle, and the sequencer advances on that edge. mem_ready=0 means
// the sequencer holds its state and counts a stall cycle. mem_ready is
// ignored in every other state. opcode only has to be valid while state
// reads REGISTER_FETCH, because it is latched on that edge.
interface control_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic [3:0]       state;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_op;
  logic             mem_fault;

  modport master (
    output opcode, mem_ready,
    input  state, instr_done, instr_count, illegal_op, mem_fault
  );

  modport slave (
    input  opcode, mem_ready,
    output state, instr_done, instr_count, illegal_op, mem_fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Multicycle control FSM. It steps each instruction through fetch, register
// fetch and its class-specific states. It stalls on memory handshakes,
// counts retired instructions and traps illegal opcodes or runaway memory
// waits into HALT.
module control_sequencer #(
  parameter int CNT_W        = 16,
  parameter int MEM_WAIT_MAX = 255
) (
  input logic                clk,
  input logic                reset,
  control_sequencer_if.slave bus
);
  // State codes are shared with ControlDecode and must not move.
  typedef enum logic [3:0] {
    S_INSTRUCTION_FETCH    = 4'd0,
    S_REGISTER_FETCH       = 4'd1,
    S_IMMEDIATE_INJECTION3 = 4'd2,
    S_ALU_R3               = 4'd3,
    S_ALU_RI3              = 4'd4,
    S_ALU4                 = 4'd5,
    S_BRANCH3              = 4'd6,
    S_MEMORY_REF3          = 4'd7,
    S_LOAD4                = 4'd8,
    S_STORE4               = 4'd9,
    S_LOAD5                = 4'd10,
    S_JUMP3                = 4'd11,
    S_HALT                 = 4'd15
  } state_t;

  // Opcode encodings.
  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_SLT  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LDI  = 6'h09;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_STR  = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h18;
  localparam logic [5:0] OP_JUMP = 6'h19;

  // The wait counter only needs to reach MEM_WAIT_MAX. With no limit it
  // just wraps, which is harmless because it is never compared.
  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 2);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

  state_t            cs;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              done_q;
  logic [CNT_W-1:0]  count_q;
  logic              illegal_q;
  logic              fault_q;

  logic [WAIT_W-1:0] wait_inc;
  logic              limit_hit;

  // Stall bookkeeping: this is the wait count after the current cycle if
  // memory does not complete. It also flags whether that count exhausts
  // the budget.
  always_comb begin
    wait_inc  = wait_cnt + WAIT_W'(1);
    limit_hit = (MEM_WAIT_MAX != 0) && !bus.mem_ready && (wait_inc >= WAIT_LIM);
  end

  // Control FSM with registered status outputs. A memory state that stalls
  // bumps the wait counter. Any other path clears it, either because memory
  // completed or because the state changed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs        <= S_INSTRUCTION_FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      wait_cnt <= '0;
      case (cs)
        S_INSTRUCTION_FETCH, S_LOAD4, S_STORE4: begin
          if (bus.mem_ready) begin
            case (cs)
              S_INSTRUCTION_FETCH: cs <= S_REGISTER_FETCH;
              S_LOAD4:             cs <= S_LOAD5;
              default: begin
                // A store retires directly out of STORE4.
                cs      <= S_INSTRUCTION_FETCH;
                done_q  <= 1'b1;
                count_q <= count_q + CNT_W'(1);
              end
            endcase
          end else if (limit_hit) begin
            cs      <= S_HALT;
            fault_q <= 1'b1;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        S_REGISTER_FETCH: begin
          op_q <= bus.opcode;
          case (bus.opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: cs <= S_ALU_R3;
            OP_ADDI:       cs <= S_ALU_RI3;
            OP_LDI:        cs <= S_IMMEDIATE_INJECTION3;
            OP_LD, OP_STR: cs <= S_MEMORY_REF3;
            OP_BEQ:        cs <= S_BRANCH3;
            OP_JUMP:       cs <= S_JUMP3;
            default: begin
              cs        <= S_HALT;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_ALU_R3, S_ALU_RI3: cs <= S_ALU4;
        // Only LD or STR can be latched when this state is reached.
        S_MEMORY_REF3: cs <= (op_q == OP_LD) ? S_LOAD4 : S_STORE4;
        S_ALU4, S_IMMEDIATE_INJECTION3, S_BRANCH3, S_JUMP3, S_LOAD5: begin
          cs      <= S_INSTRUCTION_FETCH;
          done_q  <= 1'b1;
          count_q <= count_q + CNT_W'(1);
        end
        // HALT and the unused codes park here until reset.
        default: cs <= S_HALT;
      endcase
    end
  end

  // Status outputs come straight from registers.
  always_comb begin
    bus.state       = cs;
    bus.instr_done  = done_q;
    bus.instr_count = count_q;
    bus.illegal_op  = illegal_q;
    bus.mem_fault   = fault_q;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. The reference model tracks each instruction
// as a list of control states chosen from its opcode class. It walks that
// list one entry per cycle and holds on memory states while memory is busy.
// The driver queues the expected outputs for every cycle, and a monitor on
// the falling edge compares them against the DUT.
module tb_control_sequencer;
  localparam int CNT_W = 3;
  localparam int MAX   = 4;
  localparam int W     = 4 + 1 + CNT_W + 1 + 1;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_SLT  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LDI  = 6'h09;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_STR  = 6'h11;
  localparam logic [5:0] OP_BEQ  = 6'h18;
  localparam logic [5:0] OP_JUMP = 6'h19;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_sequencer_if #(.CNT_W(CNT_W)) bus();

  control_sequencer #(.CNT_W(CNT_W), .MEM_WAIT_MAX(MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit driver_done = 0;

  logic [5:0] legal_ops[11] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI,
                                OP_LDI, OP_LD, OP_STR, OP_BEQ, OP_JUMP};

  // ---------------- reference model ----------------
  int m_path[$];
  int m_pos;
  bit m_halted, m_done, m_ill, m_fault;
  int m_count, m_wait;

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_state();
    return m_halted ? 15 : m_path[m_pos];
  endfunction

  function automatic logic [W-1:0] pack_exp();
    return {4'(m_state()), m_done, CNT_W'(m_count), m_ill, m_fault};
  endfunction

  task automatic model_step(input bit rst, input bit mr, input logic [5:0] op);
    int st;
    if (rst) begin
      m_halted = 0; m_done = 0; m_ill = 0; m_fault = 0;
      m_count = 0; m_wait = 0; m_path = '{0, 1}; m_pos = 0;
      return;
    end
    m_done = 0;
    if (m_halted) return;
    st = m_path[m_pos];
    if (st == 1) begin
      m_path = '{0, 1};
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin m_path.push_back(3); m_path.push_back(5); end
        OP_ADDI: begin m_path.push_back(4); m_path.push_back(5); end
        OP_LDI:  m_path.push_back(2);
        OP_LD:   begin m_path.push_back(7); m_path.push_back(8); m_path.push_back(10); end
        OP_STR:  begin m_path.push_back(7); m_path.push_back(9); end
        OP_BEQ:  m_path.push_back(6);
        OP_JUMP: m_path.push_back(11);
        default: begin m_halted = 1; m_ill = 1; return; end
      endcase
    end
    if ((st == 0 || st == 8 || st == 9) && !mr) begin
      m_wait++;
      if (MAX != 0 && m_wait == MAX) begin
        m_halted = 1; m_fault = 1; m_wait = 0;
      end
      return;
    end
    m_wait = 0;
    m_pos++;
    if (m_pos == m_path.size()) begin
      m_pos = 0; m_path = '{0, 1}; m_done = 1;
      m_count = (m_count + 1) % (1 << CNT_W);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: queue this cycle's expected outputs, apply the inputs,
  // advance the model and move past the edge.
  task automatic step(input bit rst, input bit mr, input logic [5:0] op);
    exp_q.push_back(pack_exp());
    reset = rst;
    bus.mem_ready = mr;
    bus.opcode = op;
    model_step(rst, mr, op);
    @(posedge clk);
    #1;
  endtask

  // Run one instruction to retirement or halt. The opcode is only valid in
  // REGISTER_FETCH and is garbage at all other times. ld_stalls busy cycles
  // are inserted in LOAD4 or STORE4.
  task automatic run_instr(input logic [5:0] op, input int ld_stalls);
    int stalls;
    int st;
    logic mr;
    logic [5:0] o;
    stalls = ld_stalls;
    for (int i = 0; i < 40; i++) begin
      st = m_state();
      mr = 1'b1;
      if ((st == 8 || st == 9) && stalls > 0) begin
        mr = 1'b0;
        stalls--;
      end
      o = (st == 1) ? op : 6'($urandom_range(0, 63));
      step(1'b0, mr, o);
      if (m_done || m_halted) break;
    end
  endtask

  function automatic logic [5:0] pick_illegal();
    logic [5:0] o;
    for (int i = 0; i < 32; i++) begin
      o = 6'($urandom_range(0, 63));
      if (!is_legal(o)) return o;
    end
    return 6'h3F;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",       int'(bus.state),       int'(e[W-1 -: 4]));
        check("instr_done",  int'(bus.instr_done),  int'(e[CNT_W+2]));
        check("instr_count", int'(bus.instr_count), int'(e[CNT_W+1:2]));
        check("illegal_op",  int'(bus.illegal_op),  int'(e[1]));
        check("mem_fault",   int'(bus.mem_fault),   int'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int burst;
    logic mr;
    logic [5:0] o;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_ADD;
    @(posedge clk);
    #1;
    model_step(1'b1, 1'b1, OP_ADD);
    step(1'b1, 1'b1, OP_ADD);

    // Every legal opcode back to back with memory always ready.
    foreach (legal_ops[i]) run_instr(legal_ops[i], 0);
    run_instr(OP_ADD, 0);

    // Loads and stores that wait in LOAD4/STORE4 without reaching the limit.
    run_instr(OP_LD, 3);
    run_instr(OP_STR, 3);
    run_instr(OP_LD, 1);

    // Memory never answers in fetch: the sequencer halts with mem_fault set.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 6'($urandom_range(0, 63)));
    step(1'b1, 1'b1, OP_ADD);

    // Exactly one stall short of the limit in fetch, then ready.
    for (int i = 0; i < MAX - 1; i++) step(1'b0, 1'b0, OP_ADD);
    run_instr(OP_ADD, 0);

    // Illegal opcode traps; the halt holds until reset.
    run_instr(6'h3F, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, OP_JUMP);
    step(1'b1, 1'b1, OP_ADD);

    // Randomized traffic, including bursts of busy memory and stray illegal opcodes.
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      st = m_state();
      if (m_halted) begin
        step($urandom_range(0, 3) == 0, 1'b1, 6'($urandom_range(0, 63)));
        continue;
      end
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 6);
      if (burst > 0) begin
        mr = 1'b0;
        burst--;
      end else begin
        mr = ($urandom_range(0, 3) != 0);
      end
      if (st == 1)
        o = ($urandom_range(0, 15) == 0) ? pick_illegal() : legal_ops[$urandom_range(0, 10)];
      else
        o = 6'($urandom_range(0, 63));
      step(1'b0, mr, o);
    end

    driver_done = 1;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
